// File: rtl/fpnorm_pipe_pkg.sv
// Shared types and constants for the normalize/round-prep pipeline.
// Rounding-mode encodings, target mantissa widths and stage bundles.
package fpnorm_pipe_pkg;

  localparam int LZW   = 8;
  localparam int EXT_W = 64;
  localparam int DBL_W = 53;
  localparam int SNG_W = 24;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RZ  = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  typedef struct packed {
    logic        sgn;
    logic [15:0] exp;
    logic [63:0] mant;
  } fp_ext_t;

  typedef struct packed {
    logic           sgn;
    logic [15:0]    exp;
    logic [127:0]   mant;
    logic [2:0]     rm;
    logic           to_dbl;
    logic           to_sng;
    logic [LZW-1:0] lz;
  } s1_t;

  typedef struct packed {
    fp_ext_t a;
    logic    rbit;
    logic    tail;
    logic    rnd;
    logic    is_dbl;
    logic    is_ext;
    logic    to_dbl;
    logic    to_sng;
    logic    zero;
    logic    unf;
    logic    ovf;
  } s2_t;

endpackage

// File: rtl/fpnorm_pipe_lzc128.sv
// Combinational 128-bit leading-zero counter.
// Returns 128 when the input is all zeros.
module lzc128
  import fpnorm_pipe_pkg::*;
(
  input  logic [127:0]   mant,
  output logic [LZW-1:0] cnt
);

  always_comb begin
    cnt = LZW'(128);
    // Ascending scan: the highest set bit is the last to win.
    for (int i = 0; i < 128; i++) begin
      if (mant[i]) cnt = LZW'(127 - i);
    end
  end

endmodule

// File: rtl/fpnorm_pipe.sv
// Two-stage left-normalize and round-prep pipeline feeding fprnd.
// S1 registers the op with its leading-zero count; S2 shifts, splits, rounds.
module fpnorm_pipe
  import fpnorm_pipe_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  logic         in_en,
  input  logic         in_sgn,
  input  logic [15:0]  in_exp,
  input  logic [127:0] in_mant,
  input  logic [2:0]   in_rmode,
  input  logic         in_toDBL,
  input  logic         in_toSNG,
  output logic         out_en,
  output logic [80:0]  out_A,
  output logic         out_rbit,
  output logic         out_tail,
  output logic         out_rndbit,
  output logic         out_isDBL,
  output logic         out_isEXT,
  output logic         out_toDBL,
  output logic         out_toSNG,
  output logic         out_zero,
  output logic         out_unf,
  output logic         out_ovf
);

  logic           v1_d, v1_q;
  logic           v2_d, v2_q;
  s1_t            s1_d, s1_q;
  s2_t            s2_d, s2_q;
  s2_t            nxt;
  logic [LZW-1:0] lz;
  logic [127:0]   norm;
  logic [63:0]    mant;
  logic [16:0]    e;
  logic           is_zero, sng, dbl;
  logic           rbit, tail, x, rnd;

  lzc128 u_lzc (
    .mant (in_mant),
    .cnt  (lz)
  );

  always_comb begin
    is_zero = s1_q.lz[7];
    norm    = is_zero ? '0 : s1_q.mant << s1_q.lz[6:0];
    sng     = s1_q.to_sng;
    dbl     = s1_q.to_dbl & ~s1_q.to_sng;
    mant    = '0;
    rbit    = 1'b0;
    tail    = 1'b0;
    unique case (1'b1)
      sng: begin
        mant = 64'(norm[127 -: SNG_W]);
        rbit = norm[127 - SNG_W];
        tail = |(norm << (SNG_W + 1));
      end
      dbl: begin
        mant = 64'(norm[127 -: DBL_W]);
        rbit = norm[127 - DBL_W];
        tail = |(norm << (DBL_W + 1));
      end
      default: begin
        mant = norm[127 -: EXT_W];
        rbit = norm[127 - EXT_W];
        tail = |(norm << (EXT_W + 1));
      end
    endcase
    x = rbit | tail;
    unique case (1'b1)
      s1_q.rm == RM_RZ:  rnd = 1'b0;
      s1_q.rm == RM_RDN: rnd = s1_q.sgn & x;
      s1_q.rm == RM_RUP: rnd = ~s1_q.sgn & x;
      s1_q.rm == RM_RMM: rnd = rbit;
      default:           rnd = rbit & (tail | mant[0]);
    endcase
    e = {1'b0, s1_q.exp} - {9'b0, s1_q.lz};
    nxt.a.sgn  = s1_q.sgn;
    nxt.a.exp  = is_zero ? 16'h0 : e[15:0];
    nxt.a.mant = mant;
    nxt.rbit   = rbit;
    nxt.tail   = tail;
    nxt.rnd    = rnd;
    nxt.is_dbl = dbl;
    nxt.is_ext = ~sng & ~dbl;
    nxt.to_dbl = dbl;
    nxt.to_sng = sng;
    nxt.zero   = is_zero;
    nxt.unf    = ~is_zero & ($signed(e) < 17'sd1);
    nxt.ovf    = ~is_zero & ($signed(e) > 17'sh07ffe);
  end

  always_comb begin
    v1_d = v1_q;
    s1_d = s1_q;
    v2_d = v2_q;
    s2_d = s2_q;
    if (!stall) begin
      v1_d = in_en;
      if (in_en) begin
        s1_d.sgn    = in_sgn;
        s1_d.exp    = in_exp;
        s1_d.mant   = in_mant;
        s1_d.rm     = in_rmode;
        s1_d.to_dbl = in_toDBL;
        s1_d.to_sng = in_toSNG;
        s1_d.lz     = lz;
      end
      v2_d = v1_q;
      if (v1_q) s2_d = nxt;
    end
    if (flush) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign out_en     = v2_q;
  assign out_A      = s2_q.a;
  assign out_rbit   = s2_q.rbit;
  assign out_tail   = s2_q.tail;
  assign out_rndbit = s2_q.rnd;
  assign out_isDBL  = s2_q.is_dbl;
  assign out_isEXT  = s2_q.is_ext;
  assign out_toDBL  = s2_q.to_dbl;
  assign out_toSNG  = s2_q.to_sng;
  assign out_zero   = s2_q.zero;
  assign out_unf    = s2_q.unf;
  assign out_ovf    = s2_q.ovf;

endmodule

// File: tb/tb_fpnorm_pipe.sv
// Directed bench for fpnorm_pipe with hand-computed expectations.
module tb_fpnorm_pipe;

  logic         clk = 1'b0;
  logic         rst, stall, flush, in_en, in_sgn;
  logic [15:0]  in_exp;
  logic [127:0] in_mant;
  logic [2:0]   in_rmode;
  logic         in_toDBL, in_toSNG;
  logic         out_en, out_rbit, out_tail, out_rndbit;
  logic [80:0]  out_A;
  logic         out_isDBL, out_isEXT, out_toDBL, out_toSNG;
  logic         out_zero, out_unf, out_ovf;

  int errs = 0;
  int checks = 0;

  fpnorm_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .in_en      (in_en),
    .in_sgn     (in_sgn),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .in_rmode   (in_rmode),
    .in_toDBL   (in_toDBL),
    .in_toSNG   (in_toSNG),
    .out_en     (out_en),
    .out_A      (out_A),
    .out_rbit   (out_rbit),
    .out_tail   (out_tail),
    .out_rndbit (out_rndbit),
    .out_isDBL  (out_isDBL),
    .out_isEXT  (out_isEXT),
    .out_toDBL  (out_toDBL),
    .out_toSNG  (out_toSNG),
    .out_zero   (out_zero),
    .out_unf    (out_unf),
    .out_ovf    (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [15:0] ex,
                       input logic [127:0] m, input logic [2:0] rm,
                       input logic dbl, input logic sng);
    in_en    = 1'b1;
    in_sgn   = s;
    in_exp   = ex;
    in_mant  = m;
    in_rmode = rm;
    in_toDBL = dbl;
    in_toSNG = sng;
  endtask

  // Issue one op, then step until it reaches the output.
  task automatic run(input logic s, input logic [15:0] ex,
                     input logic [127:0] m, input logic [2:0] rm,
                     input logic dbl, input logic sng);
    drive(s, ex, m, rm, dbl, sng);
    step();
    in_en = 1'b0;
    step();
  endtask

  task automatic chk_out(input string tag, input logic [80:0] a,
                         input logic rb, input logic tl, input logic rn);
    check({tag, ".en"}, 128'(out_en), 128'd1);
    check({tag, ".A"}, 128'(out_A), 128'(a));
    check({tag, ".rbit"}, 128'(out_rbit), 128'(rb));
    check({tag, ".tail"}, 128'(out_tail), 128'(tl));
    check({tag, ".rnd"}, 128'(out_rndbit), 128'(rn));
  endtask

  logic [127:0] m;

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 16'h0, 128'h0, 3'd0, 1'b0, 1'b0);
    in_en = 1'b0;
    step(); step();
    check("rst.en", 128'(out_en), 128'd0);
    check("rst.A", 128'(out_A), 128'd0);
    check("rst.flags", 128'({out_rbit, out_tail, out_rndbit, out_isEXT,
          out_zero, out_unf, out_ovf}), 128'd0);
    rst = 1'b0;
    step();

    // EXT normalize with exact latency
    drive(1'b0, 16'h4000, 128'h1 << 100, 3'd0, 1'b0, 1'b0);
    step();
    in_en = 1'b0;
    check("t1.lat", 128'(out_en), 128'd0);
    step();
    chk_out("t1", {1'b0, 16'h3fe5, 64'h8000_0000_0000_0000}, 0, 0, 0);
    check("t1.isEXT", 128'(out_isEXT), 128'd1);
    step();
    check("t1.drain", 128'(out_en), 128'd0);

    // DBL tie cases
    m = {{54{1'b1}}, 74'b0};
    run(1'b0, 16'h3fff, m, 3'd0, 1'b1, 1'b0);
    chk_out("t2.rne", {1'b0, 16'h3fff, 64'h001f_ffff_ffff_ffff}, 1, 0, 1);
    check("t2.isDBL", 128'(out_isDBL), 128'd1);
    run(1'b0, 16'h3fff, m, 3'd1, 1'b1, 1'b0);
    check("t2.rz", 128'(out_rndbit), 128'd0);
    run(1'b0, 16'h3fff, m, 3'd4, 1'b1, 1'b0);
    check("t2.rmm", 128'(out_rndbit), 128'd1);
    run(1'b0, 16'h3fff, m, 3'd6, 1'b1, 1'b0);
    check("t2.rm6", 128'(out_rndbit), 128'd1);
    m = {{52{1'b1}}, 1'b0, 1'b1, 74'b0};
    run(1'b0, 16'h3fff, m, 3'd0, 1'b1, 1'b0);
    chk_out("t2.even", {1'b0, 16'h3fff, 64'h001f_ffff_ffff_fffe}, 1, 0, 0);

    // SNG negative, tail-only, both targets set
    m = {1'b1, 126'b0, 1'b1};
    run(1'b1, 16'h3fff, m, 3'd2, 1'b1, 1'b1);
    chk_out("t3.rdn", {1'b1, 16'h3fff, 64'h0000_0000_0080_0000}, 0, 1, 1);
    check("t3.toSNG", 128'(out_toSNG), 128'd1);
    run(1'b1, 16'h3fff, m, 3'd3, 1'b0, 1'b1);
    check("t3.rup", 128'(out_rndbit), 128'd0);

    // Zero and exponent range
    run(1'b1, 16'h4000, 128'h0, 3'd2, 1'b0, 1'b0);
    chk_out("t4.zero", {1'b1, 16'h0, 64'h0}, 0, 0, 0);
    check("t4.zflag", 128'({out_zero, out_unf, out_ovf}), 128'b100);
    run(1'b0, 16'h0005, 128'h1 << 117, 3'd0, 1'b0, 1'b0);
    chk_out("t4.unf", {1'b0, 16'hfffb, 64'h8000_0000_0000_0000}, 0, 0, 0);
    check("t4.unfflag", 128'({out_zero, out_unf, out_ovf}), 128'b010);
    run(1'b0, 16'h0001, 128'h1 << 127, 3'd0, 1'b0, 1'b0);
    check("t4.e1", 128'({out_unf, out_ovf}), 128'b00);
    run(1'b0, 16'h7ffe, 128'h1 << 127, 3'd0, 1'b0, 1'b0);
    check("t4.e7ffe", 128'({out_unf, out_ovf}), 128'b00);
    run(1'b0, 16'h7fff, 128'h1 << 127, 3'd0, 1'b0, 1'b0);
    check("t4.ovf", 128'({out_unf, out_ovf}), 128'b01);

    // Back-to-back with stall
    drive(1'b0, 16'h4001, 128'h1 << 127, 3'd1, 1'b0, 1'b0);
    step();
    drive(1'b0, 16'h4002, 128'h1 << 127, 3'd1, 1'b0, 1'b0);
    step();
    check("t5.op1", 128'({out_en, out_A[79:64]}), 128'h1_4001);
    drive(1'b0, 16'h4003, 128'h1 << 127, 3'd1, 1'b0, 1'b0);
    stall = 1'b1;
    step();
    check("t5.hold1", 128'({out_en, out_A[79:64]}), 128'h1_4001);
    step();
    check("t5.hold2", 128'({out_en, out_A[79:64]}), 128'h1_4001);
    stall = 1'b0;
    step();
    check("t5.op2", 128'({out_en, out_A[79:64]}), 128'h1_4002);
    in_en = 1'b0;
    step();
    check("t5.op3", 128'({out_en, out_A[79:64]}), 128'h1_4003);
    step();
    check("t5.drain", 128'(out_en), 128'd0);

    // Flush together with stall
    drive(1'b0, 16'h4010, 128'h1 << 127, 3'd0, 1'b0, 1'b0);
    step();
    drive(1'b0, 16'h4011, 128'h1 << 127, 3'd0, 1'b0, 1'b0);
    step();
    in_en = 1'b0;
    stall = 1'b1;
    flush = 1'b1;
    step();
    check("t6.flush", 128'(out_en), 128'd0);
    stall = 1'b0;
    flush = 1'b0;
    step();
    check("t6.flush2", 128'(out_en), 128'd0);
    drive(1'b0, 16'h4020, 128'h1 << 127, 3'd0, 1'b0, 1'b0);
    step();
    in_en = 1'b0;
    check("t6.f.lat", 128'(out_en), 128'd0);
    step();
    check("t6.f.op", 128'({out_en, out_A[79:64]}), 128'h1_4020);

    // Reset with two ops in flight
    drive(1'b0, 16'h4030, 128'h1 << 127, 3'd0, 1'b0, 1'b0);
    step();
    drive(1'b0, 16'h4031, 128'h1 << 127, 3'd0, 1'b0, 1'b0);
    step();
    in_en = 1'b0;
    rst = 1'b1;
    step();
    check("t6.rst.en", 128'(out_en), 128'd0);
    check("t6.rst.A", 128'(out_A), 128'd0);
    rst = 1'b0;
    step();
    check("t6.rst.en2", 128'(out_en), 128'd0);
    drive(1'b0, 16'h4040, 128'h1 << 127, 3'd0, 1'b0, 1'b0);
    step();
    in_en = 1'b0;
    check("t6.r.lat", 128'(out_en), 128'd0);
    step();
    check("t6.r.op", 128'({out_en, out_A[79:64]}), 128'h1_4040);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
